spy_host: RTL and testbench
===========================

SPY_HOST -- requirements
Module: spy_host

Interface
REQ-001 Parameter TIMEOUT, default 24'd1_000_000: cycles allowed per response byte before error.
REQ-002 Port clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port cmd_req  input  1  command request; held high until cmd_ack.
REQ-005 Port cmd_ack  output  1  one-cycle pulse: command accepted.
REQ-006 Port cmd_write  input  1  1 = register write, 0 = register read.
REQ-007 Port cmd_addr  input  5  spy register address.
REQ-008 Port cmd_wdata  input  16  write data, ignored on reads.
REQ-009 Port rdata  output  16  read result, valid when done pulses after a read.
REQ-010 Port done  output  1  one-cycle pulse: command complete, success or error.
REQ-011 Port error  output  1  qualifies done: response timeout or bad response byte.
REQ-012 Port busy  output  1  high from accept until done.
REQ-013 Port rs232_txd  output  1  serial line to the spy port.
REQ-014 Port rs232_rxd  input  1  serial line from the spy port.

Function
REQ-015 Accept cmd_req only in IDLE: latch cmd_write, cmd_addr and cmd_wdata, pulse cmd_ack, raise busy; ignore cmd_req while busy.
REQ-016 Read: transmit one byte {3'b100, addr[4:0]}, then receive four response bytes.
REQ-017 Write: transmit 8'h3,8'h4,8'h5,8'h6 high nibbles carrying wdata[15:12],[11:8],[7:4],[3:0] in that order, then {3'b101, addr[4:0]}; no response expected.
REQ-018 Per TX byte: hold tx_data stable; ld_tx_req high until ld_tx_ack=1; drop ld_tx_req; wait ld_tx_ack=0; wait tx_empty=1; next byte.
REQ-019 Per RX byte: wait rx_empty=0; rx_req high until rx_ack=1; capture rx_data while rx_req is high; wait rx_ack=0.
REQ-020 Response byte k (k=0..3) must have high nibble 4'h3+k; its low nibble goes to rdata[15-4k -: 4].
REQ-021 Wrong high nibble: set error, stop receiving, go to DONE; later stray bytes are drained in IDLE.
REQ-022 Timeout counter clears at each RX-byte wait start; reaching TIMEOUT while rx_empty=1 sets error and goes to DONE.
REQ-023 DONE lasts one cycle: done=1, busy drops next cycle, return to IDLE; error holds until next accept.
REQ-024 Write completes with error=0 after the last byte reports tx_empty.
REQ-025 Read done with error=0 leaves rdata valid until the next read accept; failed reads leave partial rdata, undefined.
REQ-026 In IDLE with rx_empty=0: read and discard the byte through the normal RX handshake; cmd_req waits until the handshake completes.
REQ-027 States: IDLE, DRAIN, TX_LOAD, TX_ACK, TX_WAIT, RX_WAIT, RX_REQ, RX_REL, DONE; 3-bit byte index shared by TX and RX.

Reset
REQ-028 Reset asserted: FSM to IDLE at once, mid-command included; cmd_ack=0, done=0, error=0, busy=0, rdata=16'h0, ld_tx_req=0, rx_req=0, counters 0.
REQ-029 No command survives reset; the spy port may complete a dangling transfer, and DRAIN discards its bytes.

Structure
REQ-030 Shared package holds the opcode nibbles (4'h3..4'h6 data, 3'b100 read, 3'b101 write) for spy_host and spy_port.
REQ-031 One sub-module: the existing uart, instantiated once; rx_enable=1, tx_enable=1.

Verification
REQ-032 Read addr 5'h05, responder replies 0x3D,0x4E,0x5A,0x6D -> TX byte 0x85; done with error=0; rdata=16'hDEAD.
REQ-033 Write addr 5'h13 data 16'h1234 -> TX bytes 0x31,0x42,0x53,0x64,0xB3; done with error=0; no RX traffic.
REQ-034 Read, responder replies 0x3D,0x7E -> done with error=1 after byte two; 0x5A,0x6D are drained before the next cmd_ack.
REQ-035 Read with TIMEOUT=100, responder silent -> done with error=1 within 100 cycles (plus handshake overhead) after the TX byte completes.
REQ-036 Reset mid-way through write byte three -> busy=0, ld_tx_req=0; next read addr 5'h00 completes correctly.
REQ-037 cmd_req held through an active read -> exactly one cmd_ack per accepted command; second command starts only after done.

Source files
------------

// File: rtl/spy_host_pkg.sv
// Shared opcodes, state encoding and byte helpers for the spy host and the spy port.
package spy_host_pkg;

    localparam logic [3:0] NIB_D0   = 4'h3;
    localparam logic [3:0] NIB_D1   = 4'h4;
    localparam logic [3:0] NIB_D2   = 4'h5;
    localparam logic [3:0] NIB_D3   = 4'h6;
    localparam logic [2:0] OP_READ  = 3'b100;
    localparam logic [2:0] OP_WRITE = 3'b101;

    localparam logic [2:0] TX_LAST_WR = 3'd4;
    localparam logic [2:0] RX_LAST    = 3'd3;

    typedef enum logic [3:0] {
        IDLE, DRAIN, TX_LOAD, TX_ACK, TX_WAIT, RX_WAIT, RX_REQ, RX_REL, DONE
    } state_t;

    // Byte idx of an outgoing command: four data nibbles then the write opcode, or a lone read opcode.
    function automatic logic [7:0] tx_byte(input logic is_write, input logic [4:0] addr,
                                           input logic [15:0] wdata, input logic [2:0] idx);
        logic [7:0] b;
        b = {OP_READ, addr};
        if (is_write) begin
            case (idx)
                3'd0:    b = {NIB_D0, wdata[15:12]};
                3'd1:    b = {NIB_D1, wdata[11:8]};
                3'd2:    b = {NIB_D2, wdata[7:4]};
                3'd3:    b = {NIB_D3, wdata[3:0]};
                default: b = {OP_WRITE, addr};
            endcase
        end
        return b;
    endfunction

    function automatic logic [3:0] rx_nib(input logic [1:0] idx);
        return NIB_D0 + {2'b00, idx};
    endfunction

endpackage

// File: rtl/spy_host_uart.sv
// 8N1 UART with request/acknowledge handshakes on both the load and the receive side.
module spy_host_uart #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_enable,
    input  logic       rx_enable,
    input  logic [7:0] tx_data,
    input  logic       ld_tx_req,
    output logic       ld_tx_ack,
    output logic       tx_empty,
    output logic       txd,
    input  logic       rxd,
    output logic [7:0] rx_data,
    input  logic       rx_req,
    output logic       rx_ack,
    output logic       rx_empty
);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    logic [9:0]  tx_shift;
    logic [3:0]  tx_bits;
    logic [15:0] tx_baud;
    logic [1:0]  rx_sync;
    logic        rx_busy;
    logic [7:0]  rx_shift;
    logic [3:0]  rx_bits;
    logic [15:0] rx_baud;

    assign txd = tx_empty | tx_shift[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_tx_ack <= 1'b0;
            tx_empty  <= 1'b1;
            tx_shift  <= '1;
            tx_bits   <= 4'd0;
            tx_baud   <= 16'd0;
        end else begin
            if (!ld_tx_req) begin
                ld_tx_ack <= 1'b0;
            end else if (!ld_tx_ack && tx_empty && tx_enable) begin
                ld_tx_ack <= 1'b1;
                tx_empty  <= 1'b0;
                tx_shift  <= {1'b1, tx_data, 1'b0};
                tx_bits   <= 4'd10;
                tx_baud   <= BIT_LAST;
            end
            if (!tx_empty) begin
                if (tx_baud != 16'd0) begin
                    tx_baud <= tx_baud - 16'd1;
                end else begin
                    tx_baud  <= BIT_LAST;
                    tx_shift <= {1'b1, tx_shift[9:1]};
                    tx_bits  <= tx_bits - 4'd1;
                    if (tx_bits == 4'd1) tx_empty <= 1'b1;
                end
            end
        end
    end

    // rx_bits: 10 = start-bit check, 9..2 = data, 1 = stop bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync  <= 2'b11;
            rx_busy  <= 1'b0;
            rx_shift <= 8'h00;
            rx_bits  <= 4'd0;
            rx_baud  <= 16'd0;
            rx_data  <= 8'h00;
            rx_ack   <= 1'b0;
            rx_empty <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rxd};
            if (!rx_req) begin
                rx_ack <= 1'b0;
            end else if (!rx_ack && !rx_empty) begin
                rx_ack   <= 1'b1;
                rx_empty <= 1'b1;
            end
            if (!rx_busy) begin
                if (rx_enable && !rx_sync[1]) begin
                    rx_busy <= 1'b1;
                    rx_baud <= HALF_LAST;
                    rx_bits <= 4'd10;
                end
            end else if (rx_baud != 16'd0) begin
                rx_baud <= rx_baud - 16'd1;
            end else begin
                rx_baud <= BIT_LAST;
                rx_bits <= rx_bits - 4'd1;
                if (rx_bits == 4'd10) begin
                    if (rx_sync[1]) rx_busy <= 1'b0;
                end else if (rx_bits == 4'd1) begin
                    rx_busy <= 1'b0;
                    if (rx_sync[1]) begin
                        rx_data  <= rx_shift;
                        rx_empty <= 1'b0;
                    end
                end else begin
                    rx_shift <= {rx_sync[1], rx_shift[7:1]};
                end
            end
        end
    end

endmodule

// File: rtl/spy_host.sv
// Register read/write host for the spy port: turns one command into the serial byte exchange.
//
// state   | meaning
// IDLE    | waiting for cmd_req; stray RX bytes are drained first
// DRAIN   | discarding one stray RX byte
// TX_LOAD | present command byte idx to the UART
// TX_ACK  | ld_tx_req held until ld_tx_ack
// TX_WAIT | ld_tx_ack released and transmitter empty
// RX_WAIT | waiting for response byte idx, timeout running
// RX_REQ  | rx_req held until rx_ack, byte checked and captured
// RX_REL  | waiting for rx_ack to drop
// DONE    | one-cycle done pulse
module spy_host
    import spy_host_pkg::*;
#(
    parameter logic [23:0] TIMEOUT      = 24'd1_000_000,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_req,
    output logic        cmd_ack,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic [15:0] rdata,
    output logic        done,
    output logic        error,
    output logic        busy,
    output logic        rs232_txd,
    input  logic        rs232_rxd
);
    state_t      state;
    logic        is_write;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic [2:0]  idx;
    logic [23:0] tmo;
    logic [7:0]  tx_data;
    logic        ld_tx_req, ld_tx_ack, tx_empty;
    logic        rx_req, rx_ack, rx_empty;
    logic [7:0]  rx_data;

    spy_host_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk       (clk),
        .reset     (reset),
        .tx_enable (1'b1),
        .rx_enable (1'b1),
        .tx_data   (tx_data),
        .ld_tx_req (ld_tx_req),
        .ld_tx_ack (ld_tx_ack),
        .tx_empty  (tx_empty),
        .txd       (rs232_txd),
        .rxd       (rs232_rxd),
        .rx_data   (rx_data),
        .rx_req    (rx_req),
        .rx_ack    (rx_ack),
        .rx_empty  (rx_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            addr      <= 5'd0;
            wdata     <= 16'h0;
            idx       <= 3'd0;
            tmo       <= 24'd0;
            tx_data   <= 8'h00;
            ld_tx_req <= 1'b0;
            rx_req    <= 1'b0;
            cmd_ack   <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b0;
            rdata     <= 16'h0;
        end else begin
            cmd_ack <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_empty) begin
                        rx_req <= 1'b1;
                        state  <= DRAIN;
                    end else if (cmd_req) begin
                        is_write <= cmd_write;
                        addr     <= cmd_addr;
                        wdata    <= cmd_wdata;
                        idx      <= 3'd0;
                        cmd_ack  <= 1'b1;
                        busy     <= 1'b1;
                        error    <= 1'b0;
                        state    <= TX_LOAD;
                    end
                end
                DRAIN: begin
                    if (rx_req && rx_ack) rx_req <= 1'b0;
                    else if (!rx_req && !rx_ack) state <= IDLE;
                end
                TX_LOAD: begin
                    tx_data   <= tx_byte(is_write, addr, wdata, idx);
                    ld_tx_req <= 1'b1;
                    state     <= TX_ACK;
                end
                TX_ACK: begin
                    if (ld_tx_ack) begin
                        ld_tx_req <= 1'b0;
                        state     <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (!ld_tx_ack && tx_empty) begin
                        if (!is_write) begin
                            idx   <= 3'd0;
                            tmo   <= 24'd0;
                            state <= RX_WAIT;
                        end else if (idx == TX_LAST_WR) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= TX_LOAD;
                        end
                    end
                end
                RX_WAIT: begin
                    if (!rx_empty) begin
                        rx_req <= 1'b1;
                        state  <= RX_REQ;
                    end else if (tmo == TIMEOUT - 24'd1) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        tmo <= tmo + 24'd1;
                    end
                end
                RX_REQ: begin
                    if (rx_ack) begin
                        rx_req <= 1'b0;
                        if (rx_data[7:4] == rx_nib(idx[1:0])) begin
                            // Byte 0 lands in rdata[15:12], byte 3 in rdata[3:0].
                            rdata[{~idx[1:0], 2'b00} +: 4] <= rx_data[3:0];
                            state <= RX_REL;
                        end else begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                RX_REL: begin
                    if (!rx_ack) begin
                        if (idx == RX_LAST) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx   <= idx + 3'd1;
                            tmo   <= 24'd0;
                            state <= RX_WAIT;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spy_host.sv
// Bench for spy_host: serial monitor and responder on the RS-232 pins, scoreboarded TX bytes and results.
module tb_spy_host;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_req, cmd_write;
    logic [4:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        cmd_ack, done, error, busy;
    logic [15:0] rdata;
    logic        rs232_txd;
    logic        rs232_rxd = 1'b1;

    always #5 clk = ~clk;

    spy_host #(.TIMEOUT(24'd100), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_req   (cmd_req),
        .cmd_ack   (cmd_ack),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rdata     (rdata),
        .done      (done),
        .error     (error),
        .busy      (busy),
        .rs232_txd (rs232_txd),
        .rs232_rxd (rs232_rxd)
    );

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        logic        chk_rd;
    } res_t;

    logic [7:0] exp_tx[$];
    logic [7:0] send_q[$];
    logic [7:0] resp_b[$];
    int         resp_n[$];
    res_t       exp_res[$];

    int n_checks = 0, n_errors = 0;
    int cyc = 0, tx_cnt = 0, ack_cnt = 0, done_cnt = 0;
    int ack_cyc = 0, done_cyc = 0, tx_end_cyc = 0;
    bit mon_on = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // TX monitor and responder
    initial begin : tx_mon
        logic [7:0] mb;
        logic [7:0] exp_b;
        int         n;
        wait (reset == 1'b0);
        forever begin
            @(negedge rs232_txd);
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                mb[i] = rs232_txd;
            end
            repeat (CPB) @(negedge clk);
            tx_cnt++;
            tx_end_cyc = cyc;
            if (mon_on) begin
                check("tx_expected", {31'd0, exp_tx.size() != 0}, 32'd1);
                if (exp_tx.size() != 0) begin
                    exp_b = exp_tx.pop_front();
                    check("tx_byte", {24'd0, mb}, {24'd0, exp_b});
                end
                if (mb[7:5] == 3'b100 && resp_n.size() != 0) begin
                    n = resp_n.pop_front();
                    for (int k = 0; k < n; k++) send_q.push_back(resp_b.pop_front());
                end
            end
        end
    end

    initial begin : rx_drv
        logic [7:0] sb;
        forever begin
            @(negedge clk);
            if (send_q.size() != 0) begin
                sb = send_q.pop_front();
                rs232_rxd = 1'b0;
                repeat (CPB) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    rs232_rxd = sb[i];
                    repeat (CPB) @(negedge clk);
                end
                rs232_rxd = 1'b1;
                repeat (CPB) @(negedge clk);
            end
        end
    end

    initial begin : res_mon
        res_t r;
        forever begin
            @(posedge clk);
            #1;
            if (cmd_ack) begin
                ack_cnt++;
                ack_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("result_expected", {31'd0, exp_res.size() != 0}, 32'd1);
                if (exp_res.size() != 0) begin
                    r = exp_res.pop_front();
                    check("error", {31'd0, error}, {31'd0, r.err});
                    if (r.chk_rd) check("rdata", {16'd0, rdata}, {16'd0, r.rdata});
                end
            end
        end
    end

    task automatic plan(input int n, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] bs[4];
        bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
        resp_n.push_back(n);
        for (int i = 0; i < n; i++) resp_b.push_back(bs[i]);
    endtask

    task automatic issue(input logic wr, input logic [4:0] a, input logic [15:0] wd,
                         input logic [15:0] exp_rd, input logic exp_err, input logic chk_rd,
                         input logic want_res);
        res_t r;
        int   a0;
        if (wr) begin
            exp_tx.push_back({4'h3, wd[15:12]});
            exp_tx.push_back({4'h4, wd[11:8]});
            exp_tx.push_back({4'h5, wd[7:4]});
            exp_tx.push_back({4'h6, wd[3:0]});
            exp_tx.push_back({3'b101, a});
        end else begin
            exp_tx.push_back({3'b100, a});
        end
        if (want_res) begin
            r.rdata = exp_rd; r.err = exp_err; r.chk_rd = chk_rd;
            exp_res.push_back(r);
        end
        a0 = ack_cnt;
        @(negedge clk);
        cmd_req = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
        for (int n = 0; n < 400 && ack_cnt == a0; n++) @(negedge clk);
        check("cmd_ack_once", ack_cnt - a0, 32'd1);
        cmd_req = 1'b0;
    endtask

    task automatic wait_done(input int target, input int limit);
        for (int n = 0; n < limit && done_cnt < target; n++) @(negedge clk);
        check("done_seen", {31'd0, done_cnt >= target}, 32'd1);
    endtask

    initial begin : main
        int d, a0, t0, el;
        cmd_req = 1'b0; cmd_write = 1'b0; cmd_addr = 5'd0; cmd_wdata = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_cmd_ack", {31'd0, cmd_ack}, 32'd0);
        check("rst_rdata", {16'd0, rdata}, 32'd0);
        check("rst_txd", {31'd0, rs232_txd}, 32'd1);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // read 0x05 -> DEAD
        d = done_cnt;
        plan(4, 8'h3D, 8'h4E, 8'h5A, 8'h6D);
        issue(1'b0, 5'h05, 16'h0, 16'hDEAD, 1'b0, 1'b1, 1'b1);
        wait_done(d + 1, 2000);
        @(negedge clk);
        check("busy_after_read", {31'd0, busy}, 32'd0);

        // write 0x13 <- 1234
        d = done_cnt;
        issue(1'b1, 5'h13, 16'h1234, 16'h0, 1'b0, 1'b0, 1'b1);
        wait_done(d + 1, 2000);
        check("write_no_rx", {31'd0, dut.rx_empty}, 32'd1);

        // bad second response byte, trailing bytes must be drained
        d = done_cnt;
        plan(4, 8'h3D, 8'h7E, 8'h5A, 8'h6D);
        issue(1'b0, 5'h0A, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1);
        wait_done(d + 1, 2000);
        el = done_cyc - tx_end_cyc;
        check("err_early_stop", {31'd0, el < 130}, 32'd1);
        repeat (150) @(negedge clk);
        check("strays_drained", {31'd0, dut.rx_empty}, 32'd1);
        d = done_cnt;
        plan(4, 8'h31, 8'h42, 8'h53, 8'h64);
        issue(1'b0, 5'h01, 16'h0, 16'h1234, 1'b0, 1'b1, 1'b1);
        wait_done(d + 1, 2000);

        // silent responder -> timeout
        d = done_cnt;
        plan(0, 8'h00, 8'h00, 8'h00, 8'h00);
        issue(1'b0, 5'h1F, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1);
        wait_done(d + 1, 2000);
        el = done_cyc - tx_end_cyc;
        check("timeout_window", {31'd0, el >= 100 && el <= 112}, 32'd1);

        // reset during the third write byte
        mon_on = 1'b0;
        t0 = tx_cnt;
        issue(1'b1, 5'h0C, 16'hBEEF, 16'h0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 1000 && tx_cnt < t0 + 2; n++) @(negedge clk);
        check("two_bytes_before_rst", tx_cnt - t0, 32'd2);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ld_tx_req", {31'd0, dut.ld_tx_req}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        exp_tx.delete();
        mon_on = 1'b1;
        d = done_cnt;
        plan(4, 8'h30, 8'h41, 8'h52, 8'h63);
        issue(1'b0, 5'h00, 16'h0, 16'h0123, 1'b0, 1'b1, 1'b1);
        wait_done(d + 1, 2000);

        // cmd_req held through a read: one ack per command
        d = done_cnt;
        a0 = ack_cnt;
        plan(4, 8'h3F, 8'h4E, 8'h5D, 8'h6C);
        plan(4, 8'h3A, 8'h4B, 8'h5C, 8'h6D);
        exp_tx.push_back(8'h87);
        exp_tx.push_back(8'h87);
        exp_res.push_back('{16'hFEDC, 1'b0, 1'b1});
        exp_res.push_back('{16'hABCD, 1'b0, 1'b1});
        @(negedge clk);
        cmd_req = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h07; cmd_wdata = 16'h0;
        wait_done(d + 1, 2000);
        check("held_one_ack", ack_cnt - a0, 32'd1);
        for (int n = 0; n < 50 && ack_cnt < a0 + 2; n++) @(negedge clk);
        cmd_req = 1'b0;
        check("held_second_ack", ack_cnt - a0, 32'd2);
        check("ack_after_done", {31'd0, ack_cyc > done_cyc}, 32'd1);
        wait_done(d + 2, 2000);
        check("held_total_acks", ack_cnt - a0, 32'd2);

        repeat (20) @(negedge clk);
        check("tx_queue_empty", exp_tx.size(), 32'd0);
        check("res_queue_empty", exp_res.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
